stream_perf_monitor: RTL

Passive performance monitor for one valid/ready stream, e.g. the HOG input port or the bus-switch output. It counts transfer, stall and starve cycles, tracks the longest stall run and raises a sticky stall-timeout flag. Results are exposed as 32-bit words for lw-bridge PIOs, alongside the existing status PIOs. The HPS controls the block through a command PIO word that supports enable, clear and atomic snapshot.

---
 rtl/stream_perf_monitor_pkg.sv | 12 +
 rtl/stream_perf_monitor_sat_counter.sv | 24 ++
 rtl/stream_perf_monitor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/stream_perf_monitor_pkg.sv
// Shared bit positions for the performance monitor command and status words.
package stream_perf_monitor_pkg;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int CTRL_SNP_BIT   = 2;

  localparam int STATUS_SEQ_LSB = 24;
  localparam int STATUS_TO_BIT  = 1;
  localparam int STATUS_EN_BIT  = 0;

endpackage

// File: rtl/stream_perf_monitor_sat_counter.sv
// Synchronous saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/stream_perf_monitor.sv
// Passive valid/ready monitor: beat/stall/starve counters, longest stall run,
// sticky stall timeout, and HPS-driven clear/snapshot with registered PIO outputs.
module stream_perf_monitor
  import stream_perf_monitor_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mon_valid,
  input  logic        mon_ready,
  input  logic [31:0] ctrl_pio,
  output logic [31:0] beats_pio,
  output logic [31:0] stalls_pio,
  output logic [31:0] starves_pio,
  output logic [31:0] max_stall_pio,
  output logic [31:0] status_pio
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             enable_q;
  logic [1:0]       prev_q;
  logic             clr_ev;
  logic             snp_ev;
  logic             beat_ev;
  logic             stall_ev;
  logic             starve_ev;
  logic             run_break;
  logic [CNT_W-1:0] beats_q;
  logic [CNT_W-1:0] stalls_q;
  logic [CNT_W-1:0] starves_q;
  logic [CNT_W-1:0] cur_run;
  logic [CNT_W-1:0] run_sat;
  logic [32:0]      run_plus;
  logic [CNT_W-1:0] max_run;
  logic             timeout_flag;
  logic [7:0]       snap_seq;
  logic [31:0]      snap_beats;
  logic [31:0]      snap_stalls;
  logic [31:0]      snap_starves;
  logic [31:0]      snap_max;
  logic             unused_ctrl;

  assign unused_ctrl = ^ctrl_pio[31:3];

  assign clr_ev = ctrl_pio[CTRL_CLR_BIT] & ~prev_q[0];
  assign snp_ev = ctrl_pio[CTRL_SNP_BIT] & ~prev_q[1];

  assign beat_ev   = enable_q &  mon_valid &  mon_ready;
  assign stall_ev  = enable_q &  mon_valid & ~mon_ready;
  assign starve_ev = enable_q & ~mon_valid &  mon_ready;
  // Any counted cycle that is not a stall (including idle) ends the stall run.
  assign run_break = enable_q & ~(mon_valid & ~mon_ready);

  // 33-bit sum so the timeout compare is exact whatever CNT_W and TIMEOUT are.
  assign run_plus = 33'(cur_run) + 33'd1;
  assign run_sat  = (&cur_run) ? cur_run : cur_run + ONE;

  sat_counter #(.W(CNT_W)) u_beats (
    .clk (clk), .rst (rst), .inc (beat_ev),   .clr (clr_ev), .q (beats_q)
  );

  sat_counter #(.W(CNT_W)) u_stalls (
    .clk (clk), .rst (rst), .inc (stall_ev),  .clr (clr_ev), .q (stalls_q)
  );

  sat_counter #(.W(CNT_W)) u_starves (
    .clk (clk), .rst (rst), .inc (starve_ev), .clr (clr_ev), .q (starves_q)
  );

  sat_counter #(.W(CNT_W)) u_cur_run (
    .clk (clk), .rst (rst), .inc (stall_ev),  .clr (clr_ev | run_break), .q (cur_run)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      enable_q     <= 1'b0;
      prev_q       <= 2'b00;
      max_run      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      enable_q <= ctrl_pio[CTRL_EN_BIT];
      prev_q   <= {ctrl_pio[CTRL_SNP_BIT], ctrl_pio[CTRL_CLR_BIT]};
      if (clr_ev) begin
        max_run      <= '0;
        timeout_flag <= 1'b0;
      end else if (stall_ev) begin
        if (run_sat > max_run) max_run <= run_sat;
        if (run_plus >= 33'(TIMEOUT)) timeout_flag <= 1'b1;
      end
    end
  end

  // Snapshot samples the registered live values, so a same-cycle clear is atomic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_beats   <= '0;
      snap_stalls  <= '0;
      snap_starves <= '0;
      snap_max     <= '0;
      snap_seq     <= '0;
    end else if (snp_ev) begin
      snap_beats   <= 32'(beats_q);
      snap_stalls  <= 32'(stalls_q);
      snap_starves <= 32'(starves_q);
      snap_max     <= 32'(max_run);
      snap_seq     <= snap_seq + 8'd1;
    end
  end

  assign beats_pio     = snap_beats;
  assign stalls_pio    = snap_stalls;
  assign starves_pio   = snap_starves;
  assign max_stall_pio = snap_max;

  always_comb begin
    status_pio                          = '0;
    status_pio[STATUS_SEQ_LSB +: 8]     = snap_seq;
    status_pio[STATUS_TO_BIT]           = timeout_flag;
    status_pio[STATUS_EN_BIT]           = enable_q;
  end

endmodule
